sao_stat_accum: RTL and testbench

SAO_STAT_ACCUM -- requirements
Module: sao_stat_accum

---
 rtl/sao_stat_accum_pkg.sv | 18 +
 rtl/sao_beat_reduce.sv | 46 ++++
 rtl/sao_stat_accum.sv | 137 +++++++++++++
 tb/tb_sao_stat_accum.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sao_stat_accum_pkg.sv
// Shared defines for the SAO statistics accumulator: default geometry and FSM encodings.
package sao_stat_accum_pkg;

  // Default block geometry.
  localparam int SAO_LANES   = 16;
  localparam int SAO_DIFF_W  = 6;
  localparam int SAO_CAT_NUM = 4;
  localparam int SAO_CAT_W   = 3;
  localparam int SAO_CNT_W   = 12;
  localparam int SAO_SUM_W   = 16;

  // Accumulator FSM encodings.
  typedef logic [1:0] sao_state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACC   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/sao_beat_reduce.sv
// Combinational per-beat reduction: for each category, the number of contributing
// lanes and the sign-extended sum of their diffs.
module sao_beat_reduce
  import sao_stat_accum_pkg::*;
#(
  parameter int LANES   = SAO_LANES,
  parameter int DIFF_W  = SAO_DIFF_W,
  parameter int CAT_NUM = SAO_CAT_NUM,
  parameter int CAT_W   = SAO_CAT_W,
  parameter int RCNT_W  = $clog2(SAO_LANES + 1),
  parameter int RSUM_W  = SAO_DIFF_W + $clog2(SAO_LANES + 1)
) (
  input  logic [LANES-1:0]          lane_en_i,
  input  logic [LANES*CAT_W-1:0]    cat_i,
  input  logic [LANES*DIFF_W-1:0]   diff_i,
  output logic [CAT_NUM*RCNT_W-1:0] cnt_o,
  output logic [CAT_NUM*RSUM_W-1:0] sum_o
);

  for (genvar c = 0; c < CAT_NUM; c++) begin : g_cat
    logic [LANES-1:0]         hit;
    logic [RCNT_W-1:0]        cnt_c;
    logic signed [RSUM_W-1:0] sum_c;

    // Category codes are 1-based; code 0 and codes above CAT_NUM never match.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign hit[k] = lane_en_i[k] && (cat_i[k*CAT_W +: CAT_W] == CAT_W'(c + 1));
    end

    // Tally matching lanes and their signed diffs for this category.
    always_comb begin
      cnt_c = '0;
      sum_c = '0;
      for (int k = 0; k < LANES; k++) begin
        if (hit[k]) begin
          cnt_c = cnt_c + RCNT_W'(1);
          sum_c = sum_c + RSUM_W'($signed(diff_i[k*DIFF_W +: DIFF_W]));
        end
      end
    end

    assign cnt_o[c*RCNT_W +: RCNT_W] = cnt_c;
    assign sum_o[c*RSUM_W +: RSUM_W] = sum_c;
  end

endmodule

// File: rtl/sao_stat_accum.sv
// SAO statistics accumulator: two-stage pipeline (per-beat reduction, then saturating
// accumulation) under a three-state block FSM.
// Handshake: a beat is taken whenever valid_i=1 while in ACC; there is no ready/backpressure,
// and valid_i outside ACC (or in a start_i cycle) is dropped.
module sao_stat_accum
  import sao_stat_accum_pkg::*;
#(
  parameter int LANES   = SAO_LANES,
  parameter int DIFF_W  = SAO_DIFF_W,
  parameter int CAT_NUM = SAO_CAT_NUM,
  parameter int CAT_W   = SAO_CAT_W,
  parameter int CNT_W   = SAO_CNT_W,
  parameter int SUM_W   = SAO_SUM_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start_i,
  input  logic                     valid_i,
  input  logic                     last_i,
  input  logic [LANES-1:0]         lane_en_i,
  input  logic [LANES*CAT_W-1:0]   cat_i,
  input  logic [LANES*DIFF_W-1:0]  diff_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [CAT_NUM*CNT_W-1:0] cnt_o,
  output logic [CAT_NUM*SUM_W-1:0] sum_o,
  output logic                     sat_o,
  output logic [1:0]               state_o
);

  localparam int RCNT_W = $clog2(LANES + 1);
  localparam int RSUM_W = DIFF_W + RCNT_W;
  localparam int CNT1_W = CNT_W + 1;
  localparam int ADD_W  = ((SUM_W > RSUM_W) ? SUM_W : RSUM_W) + 1;
  localparam logic signed [ADD_W-1:0] SUM_MAX = {{(ADD_W-SUM_W+1){1'b0}}, {(SUM_W-1){1'b1}}};
  localparam logic signed [ADD_W-1:0] SUM_MIN = {{(ADD_W-SUM_W+1){1'b1}}, {(SUM_W-1){1'b0}}};

  sao_state_t                  state_q;
  logic                        done_q;
  logic                        sat_q;
  logic                        s1_vld_q;
  logic [CAT_NUM*RCNT_W-1:0]   s1_cnt_q;
  logic [CAT_NUM*RSUM_W-1:0]   s1_sum_q;
  logic [CAT_NUM*CNT_W-1:0]    cnt_q;
  logic [CAT_NUM*SUM_W-1:0]    sum_q;

  logic [CAT_NUM*RCNT_W-1:0]   red_cnt;
  logic [CAT_NUM*RSUM_W-1:0]   red_sum;
  logic [CAT_NUM*CNT_W-1:0]    cnt_d;
  logic [CAT_NUM*SUM_W-1:0]    sum_d;
  logic [CAT_NUM-1:0]          cnt_sat;
  logic [CAT_NUM-1:0]          sum_sat;
  logic                        beat_acc;

  assign beat_acc = valid_i && (state_q == ST_ACC);

  sao_beat_reduce #(
    .LANES  (LANES),
    .DIFF_W (DIFF_W),
    .CAT_NUM(CAT_NUM),
    .CAT_W  (CAT_W),
    .RCNT_W (RCNT_W),
    .RSUM_W (RSUM_W)
  ) u_reduce (
    .lane_en_i(lane_en_i),
    .cat_i    (cat_i),
    .diff_i   (diff_i),
    .cnt_o    (red_cnt),
    .sum_o    (red_sum)
  );

  // Stage 2 next values: widen by one bit, then clamp to the output range.
  for (genvar c = 0; c < CAT_NUM; c++) begin : g_acc
    logic [CNT1_W-1:0]       cnt_add;
    logic signed [ADD_W-1:0] sum_add;

    assign cnt_add = {1'b0, cnt_q[c*CNT_W +: CNT_W]} + CNT1_W'(s1_cnt_q[c*RCNT_W +: RCNT_W]);
    assign sum_add = ADD_W'($signed(sum_q[c*SUM_W +: SUM_W]))
                   + ADD_W'($signed(s1_sum_q[c*RSUM_W +: RSUM_W]));

    assign cnt_sat[c] = cnt_add[CNT_W];
    assign sum_sat[c] = (sum_add > SUM_MAX) || (sum_add < SUM_MIN);

    assign cnt_d[c*CNT_W +: CNT_W] = cnt_sat[c] ? {CNT_W{1'b1}} : cnt_add[CNT_W-1:0];
    assign sum_d[c*SUM_W +: SUM_W] = (sum_add > SUM_MAX) ? SUM_MAX[SUM_W-1:0] :
                                     (sum_add < SUM_MIN) ? SUM_MIN[SUM_W-1:0] :
                                                           sum_add[SUM_W-1:0];
  end

  // FSM, both pipeline stages and the sticky flag; start_i wins over everything but reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_cnt_q <= '0;
      s1_sum_q <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
    end else if (start_i) begin
      state_q  <= ST_ACC;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_cnt_q <= '0;
      s1_sum_q <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
    end else begin
      done_q   <= (state_q == ST_FLUSH);
      s1_vld_q <= beat_acc;
      if (beat_acc) begin
        s1_cnt_q <= red_cnt;
        s1_sum_q <= red_sum;
      end
      if (s1_vld_q) begin
        cnt_q <= cnt_d;
        sum_q <= sum_d;
        if ((|cnt_sat) || (|sum_sat)) sat_q <= 1'b1;
      end
      case (state_q)
        ST_ACC:   if (beat_acc && last_i) state_q <= ST_FLUSH;
        ST_FLUSH: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o  = (state_q != ST_IDLE) || done_q;
  assign done_o  = done_q;
  assign cnt_o   = cnt_q;
  assign sum_o   = sum_q;
  assign sat_o   = sat_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_sao_stat_accum.sv
// Directed bench for sao_stat_accum: table of single-beat blocks, hand sequences for
// multi-beat, abort, saturation and reset cases, plus a LANES=8/CAT_NUM=2 random sweep.
module tb_sao_stat_accum;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- default-geometry DUT ----------------
  logic        start, valid, last;
  logic [15:0] lane_en;
  logic [47:0] cat;
  logic [95:0] diff;
  logic        busy, done, sat;
  logic [47:0] cnt;
  logic [63:0] sum;
  logic [1:0]  state;

  sao_stat_accum dut (
    .clk(clk), .rstn(rstn), .start_i(start), .valid_i(valid), .last_i(last),
    .lane_en_i(lane_en), .cat_i(cat), .diff_i(diff),
    .busy_o(busy), .done_o(done), .cnt_o(cnt), .sum_o(sum), .sat_o(sat), .state_o(state)
  );

  // ---------------- LANES=8, CAT_NUM=2 DUT ----------------
  logic        start8, valid8, last8;
  logic [7:0]  lane_en8;
  logic [23:0] cat8;
  logic [47:0] diff8;
  logic        busy8, done8, sat8;
  logic [23:0] cnt8;
  logic [31:0] sum8;
  logic [1:0]  state8;

  sao_stat_accum #(.LANES(8), .CAT_NUM(2)) dut8 (
    .clk(clk), .rstn(rstn), .start_i(start8), .valid_i(valid8), .last_i(last8),
    .lane_en_i(lane_en8), .cat_i(cat8), .diff_i(diff8),
    .busy_o(busy8), .done_o(done8), .cnt_o(cnt8), .sum_o(sum8), .sat_o(sat8), .state_o(state8)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;
  logic [55:0] exp_q[$];

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_seen++;
  end

  typedef struct {
    logic [15:0] en;
    logic [2:0]  cat_lo;
    logic [2:0]  cat_hi;
    int          d_lo;
    int          d_hi;
    int          ec[4];
    int          es[4];
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(logic [15:0] en, logic [2:0] cl, logic [2:0] ch, int dl, int dh,
                              int c1, int c2, int c3, int c4, int s1, int s2, int s3, int s4);
    vec_t v;
    v.en = en; v.cat_lo = cl; v.cat_hi = ch; v.d_lo = dl; v.d_hi = dh;
    v.ec[0] = c1; v.ec[1] = c2; v.ec[2] = c3; v.ec[3] = c4;
    v.es[0] = s1; v.es[1] = s2; v.es[2] = s3; v.es[3] = s4;
    return v;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [47:0] mk_cat(logic [2:0] lo, logic [2:0] hi);
    logic [47:0] r;
    for (int k = 0; k < 16; k++) r[k*3 +: 3] = (k < 8) ? lo : hi;
    return r;
  endfunction

  function automatic logic [95:0] mk_diff(int lo, int hi);
    logic [95:0] r;
    for (int k = 0; k < 16; k++) r[k*6 +: 6] = (k < 8) ? 6'(lo) : 6'(hi);
    return r;
  endfunction

  function automatic logic signed [31:0] gcnt(int c);
    return {20'd0, cnt[(c-1)*12 +: 12]};
  endfunction

  function automatic logic signed [31:0] gsum(int c);
    return 32'($signed(sum[(c-1)*16 +: 16]));
  endfunction

  task automatic idle_inputs();
    start = 1'b0; valid = 1'b0; last = 1'b0; lane_en = '0; cat = '0; diff = '0;
    start8 = 1'b0; valid8 = 1'b0; last8 = 1'b0; lane_en8 = '0; cat8 = '0; diff8 = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [15:0] en, input logic [47:0] c, input logic [95:0] d, input logic l);
    lane_en = en; cat = c; diff = d; valid = 1'b1; last = l;
    tick();
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("%s cnt%0d", tag, c), gcnt(c), v.ec[c-1]);
      chk($sformatf("%s sum%0d", tag, c), gsum(c), v.es[c-1]);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int snap;
    int mc[2];
    int ms[2];
    int nb;
    logic [55:0] expv;

    idle_inputs();
    vecs[0] = mk(16'hFFFF, 3'd1, 3'd1,   3,  3, 16, 0, 0, 0,  48,   0,    0,  0);
    vecs[1] = mk(16'hFFFF, 3'd2, 3'd0,  -5, 31,  0, 8, 0, 0,   0, -40,    0,  0);
    vecs[2] = mk(16'h00FF, 3'd4, 3'd4,   1,  1,  0, 0, 0, 8,   0,   0,    0,  8);
    vecs[3] = mk(16'h0F0F, 3'd3, 3'd5, -32,  7,  0, 0, 4, 0,   0,   0, -128,  0);
    vecs[4] = mk(16'h0000, 3'd1, 3'd1,   5,  5,  0, 0, 0, 0,   0,   0,    0,  0);
    vecs[5] = mk(16'hFFFF, 3'd7, 3'd4,  31, -1,  0, 0, 0, 8,   0,   0,    0, -8);
    vecs[6] = mk(16'hAAAA, 3'd1, 3'd2,  -1,  2,  4, 4, 0, 0,  -4,   8,    0,  0);

    // Reset state.
    tick(); tick();
    chk("reset state", state, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sat", sat, 0);
    chk("reset cnt zero", cnt === '0, 1);
    chk("reset sum zero", sum === '0, 1);
    rstn = 1'b1;
    tick();

    // Table of single-beat blocks.
    for (int i = 0; i < 7; i++) begin
      pulse_start();
      chk($sformatf("v%0d state after start", i), state, 1);
      beat(vecs[i].en, mk_cat(vecs[i].cat_lo, vecs[i].cat_hi), mk_diff(vecs[i].d_lo, vecs[i].d_hi), 1'b1);
      chk($sformatf("v%0d done early", i), done, 0);
      chk($sformatf("v%0d state flush", i), state, 2);
      tick();
      chk($sformatf("v%0d done latency", i), done, 1);
      chk($sformatf("v%0d busy in done", i), busy, 1);
      chk($sformatf("v%0d sat", i), sat, 0);
      check_all($sformatf("v%0d", i), vecs[i]);
      tick();
      chk($sformatf("v%0d done one-shot", i), done, 0);
      chk($sformatf("v%0d busy idle", i), busy, 0);
    end

    // Two-beat mixed block.
    pulse_start();
    beat(16'hFFFF, mk_cat(3'd2, 3'd0), mk_diff(-5, 31), 1'b0);
    beat(16'h00FF, mk_cat(3'd4, 3'd4), mk_diff(1, 1), 1'b1);
    chk("mixed done early", done, 0);
    tick();
    chk("mixed done", done, 1);
    check_all("mixed", mk(0, 0, 0, 0, 0, 0, 8, 0, 8, 0, -40, 0, 8));
    tick();

    // Abort mid-block; a beat sharing the start_i cycle is dropped.
    snap = done_seen;
    pulse_start();
    for (int i = 0; i < 3; i++) beat(16'hFFFF, mk_cat(3'd1, 3'd1), mk_diff(3, 3), 1'b0);
    start = 1'b1;
    beat(16'hFFFF, mk_cat(3'd1, 3'd1), mk_diff(3, 3), 1'b1);
    start = 1'b0;
    beat(16'hFFFF, mk_cat(3'd3, 3'd3), mk_diff(2, 2), 1'b1);
    tick(); tick(); tick();
    chk("abort done count", done_seen - snap, 1);
    check_all("abort", mk(0, 0, 0, 0, 0, 0, 0, 16, 0, 0, 0, 32, 0));

    // Abort during FLUSH suppresses done_o.
    snap = done_seen;
    pulse_start();
    beat(16'hFFFF, mk_cat(3'd1, 3'd1), mk_diff(1, 1), 1'b1);
    pulse_start();
    chk("flush abort state", state, 1);
    tick(); tick();
    chk("flush abort no done", done_seen - snap, 0);
    chk("flush abort busy", busy, 1);
    chk("flush abort cnt1", gcnt(1), 0);
    beat(16'hFFFF, mk_cat(3'd2, 3'd2), mk_diff(1, 1), 1'b1);
    tick();
    chk("flush abort done", done, 1);
    check_all("flush abort", mk(0, 0, 0, 0, 0, 0, 16, 0, 0, 0, 16, 0, 0));
    tick();

    // Saturation over 300 beats, then hold.
    pulse_start();
    for (int i = 0; i < 300; i++) beat(16'hFFFF, mk_cat(3'd1, 3'd1), mk_diff(31, 31), (i == 299));
    tick();
    chk("sat done", done, 1);
    chk("sat cnt1", gcnt(1), 4095);
    chk("sat sum1", gsum(1), 32767);
    chk("sat flag", sat, 1);
    for (int i = 0; i < 3; i++) beat(16'hFFFF, mk_cat(3'd1, 3'd1), mk_diff(31, 31), 1'b1);
    tick();
    chk("sat hold cnt1", gcnt(1), 4095);
    chk("sat hold sum1", gsum(1), 32767);
    chk("sat hold flag", sat, 1);
    chk("sat hold busy", busy, 0);

    // Reset asserted during beat 2.
    pulse_start();
    beat(16'hFFFF, mk_cat(3'd1, 3'd1), mk_diff(3, 3), 1'b0);
    rstn = 1'b0;
    beat(16'hFFFF, mk_cat(3'd1, 3'd1), mk_diff(3, 3), 1'b0);
    rstn = 1'b1;
    chk("rst mid state", state, 0);
    chk("rst mid busy", busy, 0);
    chk("rst mid sat", sat, 0);
    chk("rst mid cnt zero", cnt === '0, 1);
    chk("rst mid sum zero", sum === '0, 1);
    snap = done_seen;
    for (int i = 0; i < 3; i++) beat(16'hFFFF, mk_cat(3'd1, 3'd1), mk_diff(3, 3), 1'b1);
    tick(); tick();
    chk("rst ignore done", done_seen - snap, 0);
    chk("rst ignore cnt1", gcnt(1), 0);
    chk("rst ignore state", state, 0);
    pulse_start();
    beat(16'hFFFF, mk_cat(3'd1, 3'd1), mk_diff(1, 1), 1'b1);
    tick();
    chk("rst resume done", done, 1);
    chk("rst resume cnt1", gcnt(1), 16);
    chk("rst resume sum1", gsum(1), 16);
    tick();

    // LANES=8, CAT_NUM=2 random sweep against a lane-by-lane model.
    for (int blk = 0; blk < 12; blk++) begin
      mc[0] = 0; mc[1] = 0; ms[0] = 0; ms[1] = 0;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 1) == 1) tick();
        lane_en8 = 8'($urandom_range(0, 255));
        for (int k = 0; k < 8; k++) begin
          int cv;
          int dv;
          cv = $urandom_range(0, 3);
          dv = $urandom_range(0, 63);
          cat8[k*3 +: 3]  = 3'(cv);
          diff8[k*6 +: 6] = 6'(dv);
          if (dv >= 32) dv = dv - 64;
          if (lane_en8[k] && cv >= 1 && cv <= 2) begin
            mc[cv-1] += 1;
            ms[cv-1] += dv;
          end
        end
        valid8 = 1'b1;
        last8 = (b == nb - 1);
        tick();
        valid8 = 1'b0;
        last8 = 1'b0;
      end
      for (int c = 0; c < 2; c++) begin
        if (mc[c] > 4095) mc[c] = 4095;
        if (ms[c] > 32767) ms[c] = 32767;
        if (ms[c] < -32768) ms[c] = -32768;
      end
      exp_q.push_back({16'(ms[1]), 16'(ms[0]), 12'(mc[1]), 12'(mc[0])});
      chk($sformatf("sweep%0d done early", blk), done8, 0);
      tick();
      chk($sformatf("sweep%0d done latency", blk), done8, 1);
      expv = exp_q.pop_front();
      n_checks++;
      if ({sum8, cnt8} !== expv) begin
        n_fail++;
        $display("FAIL sweep%0d results: got %h expected %h", blk, {sum8, cnt8}, expv);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
